// File: rtl/small_lpf_arbiter_if.sv
// Multi-channel sample bus into the shared low-pass filter and the tagged single stream out of it.
// The filter block takes the slave side; the sample sources and the consumer take the master side.
interface small_lpf_arbiter_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_BITS  = 2
);
    logic [CHANNELS-1:0]       inValid;
    logic [CHANNELS*WIDTH-1:0] inData;
    logic [CHANNELS-1:0]       inReady;
    logic                      outValid;
    logic                      outReady;
    logic [CH_BITS-1:0]        outChannel;
    logic [WIDTH-1:0]          outData;

    modport master (
        output inValid, inData, outReady,
        input  inReady, outValid, outChannel, outData
    );

    modport slave (
        input  inValid, inData, outReady,
        output inReady, outValid, outChannel, outData
    );
endinterface

// File: rtl/small_lpf_arbiter.sv
// Round-robin arbiter feeding one shared single-pole low-pass filter datapath.
// Each channel keeps its own accumulator; the result goes out tagged with its channel.
module small_lpf_arbiter #(
    parameter int WIDTH     = 8,
    parameter int FILT_BITS = 5,
    parameter int CHANNELS  = 4,
    parameter int CH_BITS   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    small_lpf_arbiter_if.slave bus
);
    localparam int ACC_W = WIDTH + FILT_BITS;

    logic signed [ACC_W-1:0] acc [CHANNELS];
    logic [CH_BITS-1:0]      rr_ptr;
    logic [CH_BITS-1:0]      grant_idx;
    logic [CH_BITS-1:0]      cand;
    logic [CH_BITS-1:0]      next_ptr;
    logic                    grant_any;
    logic                    can_accept;
    logic                    xfer;
    logic [CHANNELS-1:0]     in_ready;
    logic [WIDTH-1:0]        sample;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] acc_cur;
    logic signed [ACC_W-1:0] acc_new;
    logic                    out_valid;
    logic [CH_BITS-1:0]      out_channel;
    logic [WIDTH-1:0]        out_data;

    // First requester at or after rr_ptr, wrapping around the channel count
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = CH_BITS'((int'(rr_ptr) + i) % CHANNELS);
            if (!grant_any && bus.inValid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign can_accept = en & ~rst & (~out_valid | bus.outReady);
    assign xfer       = can_accept & grant_any;
    assign next_ptr   = (grant_idx == CH_BITS'(CHANNELS - 1)) ? '0 : grant_idx + CH_BITS'(1);

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sample = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == CH_BITS'(i)) begin
                sample = bus.inData[i*WIDTH +: WIDTH];
            end
        end
    end

    // Wrap in the intermediate sum is harmless: the final value always fits ACC_W
    assign x_ext   = {{FILT_BITS{sample[WIDTH-1]}}, sample};
    assign acc_cur = acc[grant_idx];
    assign acc_new = acc_cur + x_ext - (acc_cur >>> FILT_BITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                acc[k] <= '0;
            end
            rr_ptr      <= '0;
            out_valid   <= 1'b0;
            out_channel <= '0;
            out_data    <= '0;
        end else if (xfer) begin
            acc[grant_idx] <= acc_new;
            rr_ptr         <= next_ptr;
            out_valid      <= 1'b1;
            out_channel    <= grant_idx;
            out_data       <= acc_new[ACC_W-1 -: WIDTH];
        end else if (bus.outReady) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.inReady    = in_ready;
    assign bus.outValid   = out_valid;
    assign bus.outChannel = out_channel;
    assign bus.outData    = out_data;
endmodule

// File: tb/tb_small_lpf_arbiter.sv
// Directed bench for small_lpf_arbiter: a table of hand-computed vectors, then
// long step-response runs on ch0/ch1 checked against the filter recurrence.
`timescale 1ns/1ps
module tb_small_lpf_arbiter;
    logic clk;
    logic rst;
    logic en;

    small_lpf_arbiter_if #(.WIDTH(8), .CHANNELS(4), .CH_BITS(2)) bus ();

    small_lpf_arbiter #(
        .WIDTH(8), .FILT_BITS(5), .CHANNELS(4), .CH_BITS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en (en),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] valid;
        logic       out_ready;
        logic [3:0] exp_ready;
        logic       exp_ov;
        int         exp_ch;
        int         exp_data;
        logic       chk;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   acc_m;

    // ch3=-64, ch2=64, ch1=-128, ch0=64
    localparam logic [31:0] DATA = {8'hC0, 8'h40, 8'h80, 8'h40};

    function automatic void add(input logic r, input logic e, input logic [3:0] v,
                                input logic o, input logic [3:0] xr, input logic xov,
                                input int xch, input int xd, input logic c);
        vec_t t;
        t.rst = r; t.en = e; t.valid = v; t.out_ready = o;
        t.exp_ready = xr; t.exp_ov = xov; t.exp_ch = xch; t.exp_data = xd; t.chk = c;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.inValid = 4'b0000;
        @(posedge clk);
        #1;
        check("reset_outValid", int'(bus.outValid), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_step(input string name, input logic [3:0] valid, input int x,
                            input int ch, input int final_val);
        acc_m = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            en = 1'b1;
            bus.inValid = valid;
            bus.outReady = 1'b1;
            @(posedge clk);
            #1;
            acc_m = acc_m + x - (acc_m >>> 5);
            check({name, "_data"}, int'($signed(bus.outData)), acc_m >>> 5);
            check({name, "_ch"}, int'(bus.outChannel), ch);
        end
        check({name, "_final"}, int'($signed(bus.outData)), final_val);
    endtask

    initial begin
        int step_pos[8];
        int step_neg[5];
        vec_t v;

        rst = 1'b1;
        en = 1'b1;
        bus.inValid = 4'b0000;
        bus.inData = DATA;
        bus.outReady = 1'b1;

        step_pos = '{2, 3, 5, 7, 9, 11, 12, 14};
        step_neg = '{-4, -8, -12, -16, -19};

        // reset holds everything idle even with requests present
        add(1, 1, 4'b1111, 1, 4'b0000, 0, 0, 0, 1);
        add(1, 1, 4'b0001, 0, 4'b0000, 0, 0, 0, 1);
        foreach (step_pos[i]) add(0, 1, 4'b0001, 1, 4'b0001, 1, 0, step_pos[i], 1);
        foreach (step_neg[i]) add(0, 1, 4'b0010, 1, 4'b0010, 1, 1, step_neg[i], 1);
        // all requesting, pointer starts at 2
        add(0, 1, 4'b1111, 1, 4'b0100, 1, 2,   2, 1);
        add(0, 1, 4'b1111, 1, 4'b1000, 1, 3,  -2, 1);
        add(0, 1, 4'b1111, 1, 4'b0001, 1, 0,  16, 1);
        add(0, 1, 4'b1111, 1, 4'b0010, 1, 1, -23, 1);
        add(0, 1, 4'b1111, 1, 4'b0100, 1, 2,   3, 1);
        add(0, 1, 4'b1111, 1, 4'b1000, 1, 3,  -4, 1);
        add(0, 1, 4'b1111, 1, 4'b0001, 1, 0,  17, 1);
        add(0, 1, 4'b1111, 1, 4'b0010, 1, 1, -26, 1);
        // ch2/ch3 interleaved keep tracing their own step responses
        add(0, 1, 4'b1100, 1, 4'b0100, 1, 2,   5, 1);
        add(0, 1, 4'b1100, 1, 4'b1000, 1, 3,  -6, 1);
        add(0, 1, 4'b1100, 1, 4'b0100, 1, 2,   7, 1);
        add(0, 1, 4'b1100, 1, 4'b1000, 1, 3,  -8, 1);
        add(0, 1, 4'b0001, 1, 4'b0001, 1, 0,  19, 1);
        // backpressure freezes the output and blocks grants
        for (int i = 0; i < 5; i++) add(0, 1, 4'b1111, 0, 4'b0000, 1, 0, 19, 1);
        add(0, 1, 4'b1111, 1, 4'b0010, 1, 1, -29, 1);
        add(0, 1, 4'b1111, 1, 4'b0100, 1, 2,   9, 1);
        add(0, 1, 4'b1111, 1, 4'b1000, 1, 3, -10, 1);
        add(0, 1, 4'b0000, 1, 4'b0000, 0, 0,   0, 0);
        add(0, 1, 4'b0001, 1, 4'b0001, 1, 0,  20, 1);
        // disable: pending output holds, then drains, accumulators retained
        add(0, 0, 4'b1111, 0, 4'b0000, 1, 0,  20, 1);
        add(0, 0, 4'b1111, 1, 4'b0000, 0, 0,   0, 0);
        add(0, 0, 4'b1111, 1, 4'b0000, 0, 0,   0, 0);
        add(0, 1, 4'b1111, 1, 4'b0010, 1, 1, -32, 1);
        // reset with an output pending drops it and clears history
        add(1, 1, 4'b0001, 0, 4'b0000, 0, 0,   0, 1);
        add(0, 1, 4'b0001, 1, 4'b0001, 1, 0,   2, 1);
        add(0, 1, 4'b0001, 1, 4'b0001, 1, 0,   3, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            rst = v.rst;
            en = v.en;
            bus.inValid = v.valid;
            bus.inData = DATA;
            bus.outReady = v.out_ready;
            #1;
            check($sformatf("v%0d_inReady", i), int'(bus.inReady), int'(v.exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_outValid", i), int'(bus.outValid), int'(v.exp_ov));
            if (v.chk) begin
                check($sformatf("v%0d_outChannel", i), int'(bus.outChannel), v.exp_ch);
                check($sformatf("v%0d_outData", i), int'($signed(bus.outData)), v.exp_data);
            end
        end

        do_reset();
        run_step("conv_ch0", 4'b0001, 64, 0, 64);
        do_reset();
        run_step("conv_ch1", 4'b0010, -128, 1, -128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/small_lpf_arbiter.md
# small_lpf_arbiter

Time-multiplexed single-pole low-pass filter shared among `CHANNELS` independent sample streams. It arbitrates round-robin between requesting channels and runs one accepted sample per cycle through a single filter datapath. Filter state for each channel is kept in a per-channel accumulator bank. It sits between multi-channel sample sources (ADC demux, decimators) and downstream consumers that take a tagged single stream.

## Interface

Parameters:
- `WIDTH`, 8, sample width, signed two's complement
- `FILT_BITS`, 5, filter shift; the corner is set by 2^-FILT_BITS
- `CHANNELS`, 4, number of requesters, ≥2
- `CH_BITS`, 2, channel index width, equal to clog2(`CHANNELS`)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active high
- `en`  in  1  global enable; when 0, no new grants are issued
- `inValid`  in  `CHANNELS`  per-channel sample valid
- `inData`  in  `CHANNELS*WIDTH`  channel k sample at `[k*WIDTH +: WIDTH]`
- `inReady`  out  `CHANNELS`  per-channel accept, one-hot or zero
- `outValid`  out  1  output sample valid
- `outReady`  in  1  downstream accept
- `outChannel`  out  `CH_BITS`  channel tag of `outData`
- `outData`  out  `WIDTH`  filtered sample

## Operation

- **Accumulators:** `acc[k]`, signed, `WIDTH+FILT_BITS` bits, one per channel.
- **Update on accepting sample x for channel g:** `acc[g] <= acc[g] + x - (acc[g] >>> FILT_BITS)`. The shift is arithmetic.
- **Output value:** `outData` is `(acc[g] + x - (acc[g] >>> FILT_BITS)) >>> FILT_BITS`, i.e. the new accumulator's top `WIDTH` bits.
- **Overflow:** none, by construction. Steady-state |acc| ≤ 2^(WIDTH-1)·2^FILT_BITS. No saturation logic is used.
- **canAccept:** `en & (~outValid | outReady)`.
- **Arbitration:** round-robin with pointer `rrPtr`. The winner g is the first channel with `inValid` set, searching `rrPtr, rrPtr+1, …` modulo `CHANNELS`.
- **Grant:** `inReady[g] = canAccept & inValid[g]`. This is combinational and all other bits are 0. A transfer occurs when `inValid[g] & inReady[g]`.
- **On transfer:**
  - `acc[g]` updates.
  - The output register loads `outData`, sets `outChannel=g`, and sets `outValid=1`.
  - `rrPtr <= (g+1) mod CHANNELS`.
- **No transfer:** `rrPtr` and all `acc` hold.
- **Output handshake:** `outValid` drops after `outValid & outReady`, unless a new transfer happens in the same cycle, in which case it reloads.
- **Stability under backpressure:** while `outValid & ~outReady`, `outData` and `outChannel` are stable and `inReady` is all 0.
- **Disable:** `en=0` blocks new grants. A pending output may still drain. Accumulators are retained.
- **Channel isolation:** a channel that is never granted keeps its `acc` unchanged indefinitely.

## Timing

- **Reset:** takes effect at the next `clk` edge while `rst=1`, and overrides everything else. After reset:
  - `acc[*]=0`, `rrPtr=0`
  - `outValid=0`, `outData=0`, `outChannel=0`
  - `inReady=0` for the whole time `rst` is high
- **Reset mid-operation:** a pending output is dropped and all filter history is lost.
- **Latency:** 1 cycle. A sample transferred at edge t appears on `outData` with `outValid=1` after edge t.
- **Throughput:** one sample per cycle in aggregate when `outReady=1`.
- **Fairness:** with all channels continuously valid, each channel is granted exactly once every `CHANNELS` cycles.
- **Simultaneous drain and accept:** `outReady=1` with `outValid=1` in the same cycle as a new grant gives back-to-back outputs with no bubble.

## Test plan

- **Step on one channel:** `WIDTH=8`, `FILT_BITS=5`. Reset, then ch0 constant 64 with `outReady=1`.
  - Outputs are 2, 3, 5, …, converging to and holding 64.
  - Every output carries `outChannel=0`.
- **Negative step:** ch1 constant -128.
  - The first output is -4 (arithmetic floor).
  - Outputs converge to -128.
  - `outChannel=1` throughout.
- **Round-robin:** all four `inValid=1`, `outReady=1`.
  - Grant sequence is 0,1,2,3,0,1,…
  - `inReady` is one-hot each cycle, and `outChannel` follows one cycle later.
- **Isolation:** ch2 fed 64 and ch3 fed -64, interleaved.
  - Each channel's output sequence matches its single-channel step response exactly.
  - `acc[0]` stays 0.
- **Backpressure:**
  - Hold `outReady=0` for 5 cycles with requests pending. `outData` and `outChannel` are frozen and `inReady=0`.
  - Release `outReady`. Arbitration resumes from `rrPtr` and no sample is lost or duplicated.
- **Reset mid-stream and disable:**
  - Assert `rst` while `outValid=1`. Next cycle `outValid=0`; ch0 with input 64 then restarts at 2.
  - Set `en=0` with `inValid` high. No grants occur, and the pending output drains.
